layer3_buf_ctrl: RTL and testbench
==================================

# layer3_buf_ctrl

Initiator-side controller for the layer3 local buffer: a dual-port SRAM of 208 words × 128 bits with an 8-bit address. It turns that SRAM into a circular FIFO between the layer3 producer (conv/pool output) and the next-layer consumer. Port A is used only for writes and port B only for reads. The block sequences SRAM control so that port A and port B never present the same address with both ports active. It hides the 1-cycle SRAM read latency behind a 2-entry output queue, so it sustains one write and one read per cycle.

## Interface
Parameters:
- DEPTH, 208: number of SRAM words; pointers wrap from DEPTH-1 to 0.
- AW, 8: SRAM address width.
- DW, 128: data width.

Ports:
- CK  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush of pointers, level and output queue.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts the word (level < DEPTH and !clr).
- in_data  in  DW  producer word.
- out_valid  out  1  output queue head is valid.
- out_ready  in  1  consumer takes the head.
- out_data  out  DW  output queue head.
- level  out  AW+1  words written but not yet read-issued (0..208).
- WEAN  out  1  port A write enable, active low.
- WEBN  out  1  port B write enable, held 1.
- OEA  out  1  port A output enable, held 0.
- OEB  out  1  port B read enable, high on read issue.
- A  out  AW  port A address (wr_ptr).
- B  out  AW  port B address (rd_ptr).
- DIA  out  DW  port A write data (in_data passthrough).
- DIB  out  DW  held 0.
- DOB  in  DW  port B read data, valid the cycle after OEB=1.

## Operation
- Write: wr = in_valid && in_ready. In that cycle WEAN=0, A=wr_ptr, DIA=in_data. On the edge, wr_ptr advances with wrap 207→0.
- Read issue: rd = (level>0) && !clr && (q_cnt + pend - pop < 2), where pop = out_valid && out_ready. In that cycle OEB=1 and B=rd_ptr. On the edge, rd_ptr advances with wrap, and pend is set to 1.
- Capture: when pend=1, DOB is pushed into the 2-entry output queue on that cycle's edge, and pend is cleared unless a new rd occurs.
- level: next level = level + wr - rd. A simultaneous wr and rd leaves level unchanged. wr is blocked at level=208 and rd is blocked at level=0.
- Collision freedom: A==B with WEAN=0 and OEB=1 is impossible, because equal pointers imply level 0 (no rd) or level 208 (no wr).
- Idle: WEAN=1 and OEB=0. A and B still track the pointers, and equal addresses are harmless in this state.
- Output queue: 2-entry FIFO. out_data is the head. Simultaneous push and pop is allowed at q_cnt of 1 or 2.
- clr: wr_ptr, rd_ptr, level, q_cnt and pend all go to 0. Any in-flight DOB is discarded. In a clr cycle, in_ready=0 and OEB=0, and clr overrides everything else.
- Reset state:
  - WEAN=1, WEBN=1, OEA=0, OEB=0.
  - A=0, B=0, DIA=0, DIB=0.
  - out_valid=0, out_data=0, level=0.
  - in_ready=1 once rst_n is high.

## Timing
- Write to visible: a word accepted on edge t is read-issued in cycle t+1, captured on edge t+2, and shown with out_valid=1 in cycle t+3. Latency is 3 cycles at an empty buffer.
- Throughput: with out_ready held high, 1 word/cycle in and out; no bubbles after the initial 3-cycle fill.
- Consumer stall: at most 2 words are held in the queue plus 0 in flight. The rd gate prevents overflow: with q_cnt=2, rd occurs only in a cycle where pop=1.
- Producer stall: in_ready=0 exactly while level=208. A rd in the same cycle does not re-enable in_ready until the next cycle, because in_ready is combinational on registered level.
- Reset mid-operation: all state clears asynchronously, and stored SRAM contents are not relied upon afterwards.
- Holding out_valid: once asserted, out_valid stays high with out_data stable until pop.

## Test plan
- Basic latency: reset, then write 0x…01 on edge 0 with out_ready=1. Required: out_valid=1 in cycle 3 with out_data=0x…01, level back to 0.
- Streaming: 500 consecutive words with incrementing data, in_valid and out_ready held 1. Required: output identical and in order, pointers wrap at 207→0 twice, no gap after fill.
- Full: out_ready=0 and 212 writes offered. Required:
  - 2 words sit in the queue, level=208, in_ready=0.
  - WEAN stays 1 while full, and no A==B conflict occurs with both ports active.
  - After out_ready=1, all 210 words drain in order.
- Random backpressure: random in_valid/out_ready at 50% over 2000 cycles, checked against a reference FIFO model. Required: no loss, duplication or reordering; q_cnt ≤ 2 always.
- clr mid-stream: assert clr while level=37 with pend=1. Required:
  - The next cycle has level=0, out_valid=0, pointers at 0.
  - A word written afterwards appears 3 cycles later.
- Async reset: drop rst_n mid-burst. Required: outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/layer3_buf_ctrl.sv
`timescale 1ns / 1ps
// Circular-FIFO controller for the layer3 dual-port buffer SRAM: port A writes, port B reads.
// The 1-cycle SRAM read latency is hidden behind a 2-entry output queue.
module layer3_buf_ctrl #(
    parameter int unsigned DEPTH = 208,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 128
) (
    input  logic          CK,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          WEAN,
    output logic          WEBN,
    output logic          OEA,
    output logic          OEB,
    output logic [AW-1:0] A,
    output logic [AW-1:0] B,
    output logic [DW-1:0] DIA,
    output logic [DW-1:0] DIB,
    input  logic [DW-1:0] DOB
);

    localparam logic [AW:0]   LevelFull = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PtrLast   = AW'(DEPTH - 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          pend_q, pend_d;
    logic [1:0]    q_cnt_q, q_cnt_d;
    logic          q_head_q, q_head_d;
    logic          q_tail_q, q_tail_d;
    logic [DW-1:0] q_mem_q [2];
    logic [DW-1:0] q_mem_d [2];

    logic wr, rd, pop, push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PtrLast) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        out_valid = (q_cnt_q != 2'd0);
        in_ready  = rst_n && !clr && (level_q < LevelFull);
        wr        = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // Issue only if the queue can still absorb the word once it lands next cycle.
        rd        = (level_q != '0) && !clr &&
                    (({1'b0, q_cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop}));
        push      = pend_q && !clr;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pend_d   = pend_q;
        q_cnt_d  = q_cnt_q;
        q_head_d = q_head_q;
        q_tail_d = q_tail_q;
        q_mem_d  = q_mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            pend_d   = 1'b0;
            q_cnt_d  = 2'd0;
            q_head_d = 1'b0;
            q_tail_d = 1'b0;
        end else begin
            if (wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            level_d = level_q + (AW + 1)'(wr) - (AW + 1)'(rd);
            pend_d  = rd;
            if (push) begin
                q_mem_d[q_tail_q] = DOB;
                q_tail_d          = ~q_tail_q;
            end
            if (pop) q_head_d = ~q_head_q;
            q_cnt_d = q_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pend_q     <= 1'b0;
            q_cnt_q    <= 2'd0;
            q_head_q   <= 1'b0;
            q_tail_q   <= 1'b0;
            q_mem_q[0] <= '0;
            q_mem_q[1] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pend_q     <= pend_d;
            q_cnt_q    <= q_cnt_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            q_mem_q[0] <= q_mem_d[0];
            q_mem_q[1] <= q_mem_d[1];
        end
    end

    always_comb begin
        WEAN     = !wr;
        WEBN     = 1'b1;
        OEA      = 1'b0;
        OEB      = rd;
        A        = wr_ptr_q;
        B        = rd_ptr_q;
        // Gated so the write bus sits at zero whenever no write is issued.
        DIA      = wr ? in_data : '0;
        DIB      = '0;
        out_data = q_mem_q[q_head_q];
        level    = level_q;
    end

endmodule

// File: tb/tb_layer3_buf_ctrl.sv
`timescale 1ns / 1ps
// Scoreboard bench for layer3_buf_ctrl with a behavioural dual-port SRAM attached.
module tb_layer3_buf_ctrl;

    localparam int DEPTH = 208;
    localparam int AW    = 8;
    localparam int DW    = 128;
    typedef logic [127:0] w_t;

    logic          CK = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data, DIA, DIB;
    logic [DW-1:0] DOB = '0;
    logic [AW:0]   level;
    logic          WEAN, WEBN, OEA, OEB;
    logic [AW-1:0] A, B;

    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] next_data = '0;

    int vectors = 0;
    int miscompares = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int wrap_a = 0;
    int wrap_b = 0;
    int max_q = 0;

    always #5 CK = ~CK;

    layer3_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CK(CK), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .WEAN(WEAN), .WEBN(WEBN), .OEA(OEA), .OEB(OEB),
        .A(A), .B(B), .DIA(DIA), .DIB(DIB), .DOB(DOB)
    );

    always @(posedge CK) begin
        if (!WEAN) sram[A] <= DIA;
        if (OEB) DOB <= sram[B];
    end

    task automatic flag(input string name, input w_t act, input w_t req);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic chk(input string name, input w_t act, input w_t req);
        if (act !== req) flag(name, act, req);
        else vectors++;
    endtask

    // Stimulus side: every accepted word becomes an expected output.
    always @(negedge CK) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(in_data);
            acc_cnt++;
        end
    end

    always @(negedge rst_n) exp_q.delete();

    // Monitor: pops and compares whenever the consumer takes a word.
    always @(negedge CK) begin
        if (rst_n) begin
            if (clr) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) flag("out_unexpected", w_t'(out_data), '0);
                else chk("out_data", w_t'(out_data), w_t'(exp_q.pop_front()));
            end
            if (!WEAN && OEB && (A == B)) flag("port_collision", w_t'(A), w_t'(B));
            if ((level == 9'(DEPTH)) && !WEAN) flag("wean_while_full", w_t'(WEAN), 1);
            if (int'(dut.q_cnt_q) > max_q) max_q = int'(dut.q_cnt_q);
            if (!WEAN && (A == 8'(DEPTH - 1))) wrap_a++;
            if (OEB && (B == 8'(DEPTH - 1))) wrap_b++;
        end
    end

    task automatic step(input logic iv, input logic ordy, input logic c);
        @(posedge CK);
        #1;
        in_valid  = iv;
        out_ready = ordy;
        clr       = c;
        in_data   = next_data;
        @(negedge CK);
        if (in_valid && in_ready) next_data = next_data + 1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", w_t'(exp_q.size()), 0);
        chk("drain_level", w_t'(level), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, last, nvalid, acc0, pop0;

        // Reset values while rst_n is low.
        #3;
        chk("rst_wean", w_t'(WEAN), 1);
        chk("rst_webn", w_t'(WEBN), 1);
        chk("rst_oea", w_t'(OEA), 0);
        chk("rst_oeb", w_t'(OEB), 0);
        chk("rst_a", w_t'(A), 0);
        chk("rst_b", w_t'(B), 0);
        chk("rst_dia", w_t'(DIA), 0);
        chk("rst_dib", w_t'(DIB), 0);
        chk("rst_out_valid", w_t'(out_valid), 0);
        chk("rst_out_data", w_t'(out_data), 0);
        chk("rst_level", w_t'(level), 0);
        #10 rst_n = 1'b1;
        #1 chk("rst_in_ready", w_t'(in_ready), 1);

        // Basic latency: one word, visible three cycles after acceptance.
        next_data = 128'h1;
        step(1'b1, 1'b1, 1'b0);
        chk("lat_wean", w_t'(WEAN), 0);
        chk("lat_dia", w_t'(DIA), 128'h1);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_c1_valid", w_t'(out_valid), 0);
        chk("lat_c1_oeb", w_t'(OEB), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_c2_valid", w_t'(out_valid), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_c3_valid", w_t'(out_valid), 1);
        chk("lat_c3_data", w_t'(out_data), 128'h1);
        chk("lat_c3_level", w_t'(level), 0);
        drain(10);

        // Streaming: 500 words, no bubbles after fill, both pointers wrap twice.
        next_data = 128'h1000;
        wrap_a = 0;
        wrap_b = 0;
        first = -1;
        last = -1;
        nvalid = 0;
        for (int i = 0; i < 520; i++) begin
            step(i < 500, 1'b1, 1'b0);
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                nvalid++;
            end
        end
        chk("stream_count", w_t'(nvalid), 500);
        chk("stream_first", w_t'(first), 3);
        chk("stream_last", w_t'(last), 502);
        chk("stream_wrap_a", w_t'(wrap_a), 2);
        chk("stream_wrap_b", w_t'(wrap_b), 2);

        // Full: consumer stalled, producer offers more than fits.
        next_data = 128'h2000;
        acc0 = acc_cnt;
        for (int i = 0; i < 240; i++) step(1'b1, 1'b0, 1'b0);
        chk("full_level", w_t'(level), 208);
        chk("full_in_ready", w_t'(in_ready), 0);
        chk("full_out_valid", w_t'(out_valid), 1);
        chk("full_head", w_t'(out_data), 128'h2000);
        chk("full_accepted", w_t'(acc_cnt - acc0), 210);
        pop0 = pop_cnt;
        step(1'b0, 1'b1, 1'b0);
        chk("full_rd_cycle_ready", w_t'(in_ready), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("full_next_ready", w_t'(in_ready), 1);
        chk("full_next_level", w_t'(level), 207);
        drain(300);
        chk("full_drained", w_t'(pop_cnt - pop0), 210);

        // Random backpressure against the scoreboard.
        next_data = 128'h10000;
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        drain(400);
        chk("q_cnt_le2", w_t'(max_q <= 2), 1);

        // clr with level 37 and a read in flight.
        next_data = 128'h3000;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_pre_level", w_t'(level), 37);
        chk("clr_pre_pend", w_t'(dut.pend_q), 1);
        chk("clr_oeb", w_t'(OEB), 0);
        chk("clr_in_ready", w_t'(in_ready), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_level", w_t'(level), 0);
        chk("clr_out_valid", w_t'(out_valid), 0);
        chk("clr_a", w_t'(A), 0);
        chk("clr_b", w_t'(B), 0);
        next_data = 128'hC1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("clr_c1_valid", w_t'(out_valid), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("clr_c2_valid", w_t'(out_valid), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("clr_c3_valid", w_t'(out_valid), 1);
        chk("clr_c3_data", w_t'(out_data), 128'hC1);
        drain(10);

        // Asynchronous reset in the middle of a burst, checked before any edge.
        next_data = 128'h4000;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        @(posedge CK);
        #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", w_t'(out_valid), 0);
        chk("arst_level", w_t'(level), 0);
        chk("arst_wean", w_t'(WEAN), 1);
        chk("arst_oeb", w_t'(OEB), 0);
        chk("arst_a", w_t'(A), 0);
        chk("arst_b", w_t'(B), 0);
        chk("arst_dia", w_t'(DIA), 0);
        chk("arst_out_data", w_t'(out_data), 0);
        in_valid = 1'b0;
        @(negedge CK);
        @(negedge CK);
        rst_n = 1'b1;
        next_data = 128'h5000;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
